// File: rtl/scalar_mult_ctrl.sv
// Sequencer for left-to-right double-and-add scalar multiplication.
// Drives an external combinational point ALU and accumulates its results in Q.
module scalar_mult_ctrl #(
  parameter int KBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KBITS-1:0] k,
  input  logic [11:0]      P,
  output logic             alu_op,
  output logic [11:0]      alu_a,
  output logic [11:0]      alu_b,
  output logic             alu_en,
  input  logic [11:0]      alu_r,
  output logic [11:0]      result,
  output logic             busy,
  output logic             done
);

  localparam int IW = (KBITS > 1) ? $clog2(KBITS) : 1;
  localparam logic [11:0] INF_PT = 12'h010;

  typedef enum logic [2:0] {IDLE, SCAN, DBL, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [KBITS-1:0] kr_q, kr_d;
  logic [11:0]      pr_q, pr_d;
  logic [11:0]      q_q, q_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [11:0]      result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aluEn_q, aluEn_d;
  logic             aluOp_q, aluOp_d;
  logic [IW-1:0]    msbIdx;

  always_comb begin
    msbIdx = '0;
    for (int i = 0; i < KBITS; i++) begin
      if (kr_q[i]) msbIdx = IW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    kr_d     = kr_q;
    pr_d     = pr_q;
    q_d      = q_q;
    idx_d    = idx_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          kr_d    = k;
          pr_d    = P;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (kr_q == '0) begin
          q_d     = INF_PT;
          state_d = DONE;
        end else begin
          q_d = pr_q;
          // A lone bit 0 needs no ALU work; keep idx at 0 rather than wrapping.
          if (msbIdx == '0) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d   = msbIdx - IW'(1);
            state_d = DBL;
          end
        end
      end
      DBL: begin
        q_d = alu_r;
        if (kr_q[idx_q]) begin
          state_d = ADD;
        end else if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      ADD: begin
        q_d = alu_r;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = DBL;
        end
      end
      DONE: begin
        result_d = q_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == DONE);
    aluEn_d = (state_d == DBL) || (state_d == ADD);
    aluOp_d = (state_d == DBL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      kr_q     <= '0;
      pr_q     <= '0;
      q_q      <= INF_PT;
      idx_q    <= '0;
      result_q <= INF_PT;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      aluEn_q  <= 1'b0;
      aluOp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kr_q     <= kr_d;
      pr_q     <= pr_d;
      q_q      <= q_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      aluEn_q  <= aluEn_d;
      aluOp_q  <= aluOp_d;
    end
  end

  assign alu_a  = q_q;
  assign alu_b  = pr_q;
  assign alu_op = aluOp_q;
  assign alu_en = aluEn_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl: stub ALU tags each result with its op count, and
// a bit-scan reference model predicts op sequence, latency and final result.
module tb_scalar_mult_ctrl;

  localparam int BUDGET = 40;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  k;
  logic [11:0] P;
  logic        alu_op, alu_en, busy, done;
  logic [11:0] alu_a, alu_b, alu_r, result;

  logic        cntClr;
  logic [7:0]  cnt;
  logic [7:0]  cntPlus;

  int          total = 0;
  int          bad = 0;
  logic [15:0] obsOps;
  int          obsN;
  int          doneCyc;
  int          doneCount;
  logic [11:0] expRes;

  scalar_mult_ctrl #(.KBITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .k(k), .P(P),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_en(alu_en),
    .alu_r(alu_r), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign cntPlus = cnt + 8'd1;
  assign alu_r   = (alu_op ? 12'hD00 : 12'hA00) | {4'h0, cntPlus};

  always @(posedge clk) begin
    if (cntClr) cnt <= 8'd0;
    else if (alu_en) cnt <= cnt + 8'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Left-to-right binary method: one double per bit below the MSB, plus an add per set bit.
  function automatic void refModel(input logic [3:0] kv, input logic [11:0] pv,
                                   output logic [15:0] ops, output int n,
                                   output int lat, output logic [11:0] res);
    int m;
    ops = '0;
    n   = 0;
    if (kv == 4'd0) begin
      lat = 2;
      res = 12'h010;
      return;
    end
    m = 0;
    for (int i = 0; i < 4; i++) if (kv[i]) m = i;
    for (int i = m - 1; i >= 0; i--) begin
      ops[n] = 1'b1;
      n++;
      if (kv[i]) begin
        ops[n] = 1'b0;
        n++;
      end
    end
    lat = 2 + m + $countones(kv) - 1;
    if (n == 0) res = pv;
    else res = (ops[n-1] ? 12'hD00 : 12'hA00) | 12'(n);
  endfunction

  task automatic applyStimulus(input logic [3:0] kv, input logic [11:0] pv, input bit holdStart,
                               input bit noise, input int rstAt, input string tag);
    logic [15:0] eOps;
    int          eN, eLat;
    logic [11:0] eRes;
    refModel(kv, pv, eOps, eN, eLat, eRes);
    obsOps    = '0;
    obsN      = 0;
    doneCyc   = -1;
    doneCount = 0;
    start  = 1'b1;
    k      = kv;
    P      = pv;
    cntClr = 1'b1;
    @(posedge clk);
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cntClr = 1'b0;
        if (!holdStart) start = 1'b0;
        checkOutput({tag, "_busy0"}, busy, 1);
        checkOutput({tag, "_done0"}, done, 0);
        checkOutput({tag, "_aluB"}, alu_b, pv);
      end
      if (noise && c >= 1 && c <= 3) begin
        start = 1'($urandom);
        k     = 4'($urandom);
        P     = 12'($urandom);
      end
      if (noise && c == 4) start = holdStart;
      if (!alu_en) checkOutput({tag, "_opIdle"}, alu_op, 0);
      if (alu_en && obsN < 16) begin
        obsOps[obsN] = alu_op;
        obsN++;
      end
      if (rstAt >= 0 && c == rstAt) rst = 1'b1;
      if (rstAt >= 0 && c == rstAt + 1) begin
        checkOutput({tag, "_rstBusy"}, busy, 0);
        checkOutput({tag, "_rstResult"}, result, 12'h010);
        checkOutput({tag, "_rstAluEn"}, alu_en, 0);
        rst = 1'b0;
      end
      if (done) begin
        doneCount++;
        if (doneCyc < 0) doneCyc = c;
        if (rstAt < 0) break;
      end
      if (rstAt >= 0 && c == rstAt + 8) break;
    end
    if (rstAt < 0) begin
      expRes = eRes;
      checkOutput({tag, "_ops"}, obsOps, eOps);
      checkOutput({tag, "_nOps"}, obsN, eN);
      checkOutput({tag, "_doneCyc"}, doneCyc, eLat);
      checkOutput({tag, "_result"}, result, eRes);
    end
  endtask

  task automatic postCheck(input string tag);
    @(negedge clk);
    checkOutput({tag, "_doneWidth"}, done, 0);
    checkOutput({tag, "_hold"}, result, expRes);
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    k      = 4'd0;
    P      = 12'd0;
    cntClr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_result", result, 12'h010);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_aluEn", alu_en, 0);
    checkOutput("rst_aluOp", alu_op, 0);
    checkOutput("rst_aluA", alu_a, 12'h010);
    checkOutput("rst_aluB", alu_b, 12'h000);

    // Reset and start together: reset must win.
    start = 1'b1;
    k     = 4'd5;
    P     = 12'h777;
    @(negedge clk);
    checkOutput("rstStart_busy", busy, 0);
    checkOutput("rstStart_aluB", alu_b, 12'h000);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rstStart_idle", busy, 0);

    applyStimulus(4'b1011, 12'h123, 1'b0, 1'b0, -1, "k1011");
    checkOutput("k1011_seqLit", obsOps, 16'b01011);
    checkOutput("k1011_doneLit", doneCyc, 7);
    checkOutput("k1011_resLit", result, 12'hA05);
    postCheck("k1011");

    applyStimulus(4'b0000, 12'h5A3, 1'b0, 1'b0, -1, "k0");
    checkOutput("k0_nLit", obsN, 0);
    checkOutput("k0_doneLit", doneCyc, 2);
    checkOutput("k0_resLit", result, 12'h010);
    postCheck("k0");

    applyStimulus(4'b0001, 12'h5A3, 1'b0, 1'b0, -1, "k1");
    checkOutput("k1_nLit", obsN, 0);
    checkOutput("k1_doneLit", doneCyc, 2);
    checkOutput("k1_resLit", result, 12'h5A3);
    postCheck("k1");

    applyStimulus(4'b1000, 12'h3C5, 1'b0, 1'b1, -1, "k1000");
    checkOutput("k1000_seqLit", obsOps, 16'b111);
    checkOutput("k1000_nLit", obsN, 3);
    checkOutput("k1000_doneLit", doneCyc, 5);
    checkOutput("k1000_resLit", result, 12'hD03);
    postCheck("k1000");

    applyStimulus(4'b1111, 12'h246, 1'b0, 1'b0, 4, "k1111rst");
    checkOutput("k1111rst_noDone", doneCount, 0);
    checkOutput("k1111rst_result", result, 12'h010);

    applyStimulus(4'b0011, 12'h9B1, 1'b0, 1'b0, -1, "k0011");
    checkOutput("k0011_seqLit", obsOps, 16'b01);
    checkOutput("k0011_doneLit", doneCyc, 4);
    postCheck("k0011");

    applyStimulus(4'b0101, 12'h111, 1'b1, 1'b0, -1, "b2b_a");
    applyStimulus(4'b1110, 12'h222, 1'b1, 1'b0, -1, "b2b_b");
    applyStimulus(4'b0010, 12'h333, 1'b1, 1'b0, -1, "b2b_c");
    start = 1'b0;
    @(negedge clk);
    checkOutput("b2b_lastWidth", done, 0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'($urandom), 12'($urandom), 1'b0, 1'b0, -1, "rnd");
      postCheck("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
